// File: rtl/ones_acc_pkg.sv
// Shared definitions for the ones accumulator: the FSM state encoding and
// the width helper used to size the sum and beat-count registers.
package ones_acc_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_e;

    // Smallest n with 2**n >= v.
    function automatic int clog2(input int v);
        int n;
        n = 0;
        while ((1 << n) < v) n++;
        return n;
    endfunction

endpackage

// File: rtl/ones_acc_ctrl.sv
// Window control FSM: collects beats in ACCUM and presents the result in HOLD
// until the consumer takes it.
module ones_acc_ctrl
    import ones_acc_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic flush,
    input  logic out_ready,
    input  logic last_slot,
    output logic in_ready,
    output logic out_valid,
    output logic load,
    output logic clear
);

    acc_state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ACCUM;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        load      = 1'b0;
        clear     = 1'b0;
        case (state_q)
            ACCUM: begin
                in_ready = 1'b1;
                load     = in_valid;
                // A beat arriving together with flush is folded into this window.
                if ((in_valid && last_slot) || flush) state_d = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    clear   = 1'b1;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

endmodule

// File: rtl/ones_accumulator.sv
// Sums per-beat ones counts over a window of WINDOW accepted beats (or until
// flush) and hands the total plus beat count downstream with valid/ready.
module ones_accumulator
    import ones_acc_pkg::*;
#(
    parameter  int WINDOW = 8,
    localparam int SUM_W  = clog2(3 * WINDOW + 1),
    localparam int CNT_W  = clog2(WINDOW + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [1:0]       in_count,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    output logic [SUM_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_beats,
    input  logic             out_ready
);

    logic [SUM_W-1:0] sum_q;
    logic [CNT_W-1:0] beats_q;
    logic             load;
    logic             clear;
    logic             last_slot;

    assign last_slot = (beats_q == CNT_W'(WINDOW - 1));

    ones_acc_ctrl u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .flush     (flush),
        .out_ready (out_ready),
        .last_slot (last_slot),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .load      (load),
        .clear     (clear)
    );

    // 3*WINDOW always fits SUM_W, so the adder cannot wrap.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            sum_q   <= '0;
            beats_q <= '0;
        end else if (load) begin
            sum_q   <= sum_q + {{(SUM_W-2){1'b0}}, in_count};
            beats_q <= beats_q + CNT_W'(1);
        end
    end

    assign out_sum   = out_valid ? sum_q   : '0;
    assign out_beats = out_valid ? beats_q : '0;

endmodule

// File: tb/tb_ones_accumulator.sv
// Bench for ones_accumulator: table of windows, backpressure / reset / max-sum
// sequences, and randomized traffic against a window-level reference model.
module tb_ones_accumulator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, flush, out_ready, in_ready, out_valid;
    logic [1:0] in_count;
    logic [4:0] out_sum;
    logic [3:0] out_beats;

    logic       v64, f64, ordy64, irdy64, ov64;
    logic [1:0] c64;
    logic [7:0] sum64;
    logic [6:0] beats64;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ones_accumulator #(.WINDOW(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_count(in_count),
        .in_ready(in_ready), .flush(flush), .out_valid(out_valid),
        .out_sum(out_sum), .out_beats(out_beats), .out_ready(out_ready)
    );

    ones_accumulator #(.WINDOW(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(v64), .in_count(c64),
        .in_ready(irdy64), .flush(f64), .out_valid(ov64),
        .out_sum(sum64), .out_beats(beats64), .out_ready(ordy64)
    );

    typedef struct {
        int n;
        bit fl;
        int cnt[8];
        int es;
        int eb;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // All driving and sampling happens on the falling edge.
    task automatic beats_const(input int val, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_count = 2'(val);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic expect_result(input string name, input int es, input int eb);
        chk({name, "_valid"}, int'(out_valid), 1);
        chk({name, "_sum"}, int'(out_sum), es);
        chk({name, "_beats"}, int'(out_beats), eb);
        chk({name, "_ready_low"}, int'(in_ready), 0);
        out_ready = 1'b1;
        @(negedge clk);
        chk({name, "_released"}, int'(out_valid), 0);
        chk({name, "_zero_sum"}, int'(out_sum), 0);
    endtask

    task automatic run_vec(input vec_t v);
        out_ready = 1'b1;
        if (v.n == 0) begin
            flush = 1'b1;
            @(negedge clk);
        end else begin
            for (int i = 0; i < v.n; i++) begin
                chk("vec_in_ready", int'(in_ready), 1);
                in_valid = 1'b1;
                in_count = 2'(v.cnt[i]);
                flush    = v.fl && (i == v.n - 1);
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        expect_result("vec", v.es, v.eb);
    endtask

    // Reference model: list of counts accepted into the open window.
    int  q[$];
    bit  m_hold;
    int  m_sum;

    initial begin
        tbl[0] = '{n:0, fl:1'b1, cnt:'{0,0,0,0,0,0,0,0}, es:0,  eb:0};
        tbl[1] = '{n:8, fl:1'b0, cnt:'{3,1,0,2,3,3,1,2}, es:15, eb:8};
        tbl[2] = '{n:4, fl:1'b1, cnt:'{2,3,1,2,0,0,0,0}, es:8,  eb:4};
        tbl[3] = '{n:8, fl:1'b0, cnt:'{3,3,3,3,3,3,3,3}, es:24, eb:8};
        tbl[4] = '{n:1, fl:1'b1, cnt:'{1,0,0,0,0,0,0,0}, es:1,  eb:1};
        tbl[5] = '{n:8, fl:1'b0, cnt:'{0,0,0,0,0,0,0,0}, es:0,  eb:8};

        rst_n = 1'b0; in_valid = 1'b0; in_count = 2'd0; flush = 1'b0; out_ready = 1'b0;
        v64 = 1'b0; c64 = 2'd0; f64 = 1'b0; ordy64 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_sum", int'(out_sum), 0);
        chk("rst_out_beats", int'(out_beats), 0);
        rst_n = 1'b1;
        chk("rst_in_ready", int'(in_ready), 1);

        // Table: the empty flush lands right after reset.
        for (int t = 0; t < 6; t++) run_vec(tbl[t]);

        // Backpressure with flush in HOLD (must be ignored) and offered beats.
        out_ready = 1'b0;
        beats_const(1, 8);
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_sum", int'(out_sum), 8);
            chk("bp_beats", int'(out_beats), 8);
            chk("bp_in_ready", int'(in_ready), 0);
            in_valid = 1'b1;
            in_count = 2'd3;
            flush    = (k == 2);
            @(negedge clk);
        end
        flush = 1'b0;
        in_valid = 1'b0;
        expect_result("bp_release", 8, 8);
        chk("bp_in_ready_after", int'(in_ready), 1);
        beats_const(2, 8);
        expect_result("bp_next", 16, 8);

        // Reset mid-window.
        beats_const(3, 5);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstmid_valid", int'(out_valid), 0);
        rst_n = 1'b1;
        chk("rstmid_in_ready", int'(in_ready), 1);
        @(negedge clk);
        chk("rstmid_no_emit", int'(out_valid), 0);
        // Reset during HOLD.
        out_ready = 1'b0;
        beats_const(3, 8);
        chk("rsthold_in_hold", int'(out_valid), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rsthold_dropped", int'(out_valid), 0);
        chk("rsthold_sum", int'(out_sum), 0);
        chk("rsthold_in_ready", int'(in_ready), 1);
        beats_const(1, 7);
        in_valid = 1'b1; in_count = 2'd2;
        @(negedge clk);
        in_valid = 1'b0;
        expect_result("rst_next", 9, 8);

        // WINDOW = 64 max sum.
        ordy64 = 1'b1;
        for (int i = 0; i < 64; i++) begin
            v64 = 1'b1; c64 = 2'd3;
            @(negedge clk);
        end
        v64 = 1'b0;
        chk("w64_valid", int'(ov64), 1);
        chk("w64_sum", int'(sum64), 192);
        chk("w64_beats", int'(beats64), 64);
        @(negedge clk);
        chk("w64_released", int'(ov64), 0);

        // Randomized traffic vs window-level model.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        m_hold = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            m_sum = 0;
            foreach (q[j]) m_sum += q[j];
            chk("rnd_in_ready", int'(in_ready), m_hold ? 0 : 1);
            chk("rnd_out_valid", int'(out_valid), m_hold ? 1 : 0);
            chk("rnd_out_sum", int'(out_sum), m_hold ? m_sum : 0);
            chk("rnd_out_beats", int'(out_beats), m_hold ? q.size() : 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_count  = 2'($urandom_range(0, 3));
            flush     = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            if (!m_hold) begin
                if (in_valid) q.push_back(int'(in_count));
                if (q.size() == 8 || flush) m_hold = 1'b1;
            end else if (out_ready) begin
                m_hold = 1'b0;
                q.delete();
            end
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ones_accumulator.md
ONES_ACCUMULATOR -- requirements
Module: ones_accumulator

Interface
REQ-001 SHALL have parameter WINDOW, default 8, number of accepted beats per window; legal range 2..64.
REQ-002 SHALL derive localparam SUM_W = clog2(3*WINDOW+1), default 5, width of window sum.
REQ-003 SHALL derive localparam CNT_W = clog2(WINDOW+1), default 4, width of beat count.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  upstream beat present.
REQ-007 in_count  input  2  per-beat ones count from the 3-input ones-counter stage, values 0..3.
REQ-008 in_ready  output  1  block accepts beat this cycle.
REQ-009 flush  input  1  close the current window early.
REQ-010 out_valid  output  1  window result present.
REQ-011 out_sum  output  SUM_W  sum of in_count over the closed window.
REQ-012 out_beats  output  CNT_W  number of beats in the closed window.
REQ-013 out_ready  input  1  downstream takes result this cycle.

Function
REQ-014 SHALL implement two states: ACCUM (collecting beats) and HOLD (result presented).
REQ-015 Beat accepted iff in_valid && in_ready; in_ready SHALL be 1 in ACCUM, 0 in HOLD.
REQ-016 On accepted beat in ACCUM: sum <= sum + in_count (zero-extended), beats <= beats + 1.
REQ-017 When accepted beat makes beats == WINDOW, SHALL move to HOLD next cycle; out_valid rises the cycle after that last beat (latency 1).
REQ-018 flush in ACCUM SHALL move to HOLD next cycle; a beat accepted in the same cycle SHALL be included in out_sum/out_beats.
REQ-019 flush with zero beats accumulated SHALL still produce a result with out_sum = 0, out_beats = 0.
REQ-020 flush in HOLD SHALL be ignored.
REQ-021 In HOLD, out_valid = 1 and out_sum/out_beats SHALL stay stable until out_valid && out_ready.
REQ-022 On out_ready in HOLD: next cycle ACCUM, sum = 0, beats = 0, out_valid = 0; no beat accepted in the handoff cycle (in_ready = 0 that cycle).
REQ-023 Sum SHALL never overflow: maximum 3*WINDOW fits SUM_W by construction; no saturation logic.
REQ-024 out_valid SHALL be 0 in ACCUM; out_sum/out_beats SHALL read 0 in ACCUM.
REQ-025 in_valid with in_ready = 0 SHALL have no effect; upstream holds the beat.

Reset
REQ-026 rst_n == 0 at a rising edge SHALL force state ACCUM, sum = 0, beats = 0, out_valid = 0, out_sum = 0, out_beats = 0.
REQ-027 Reset mid-window or in HOLD SHALL discard the partial/pending result without emitting it.
REQ-028 in_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-029 Shared package ones_acc_pkg SHALL hold state encoding (ACCUM = 1'b0, HOLD = 1'b1) and the clog2 width function.
REQ-030 Control FSM SHALL be a sub-module ones_acc_ctrl (state, in_ready, out_valid, clear/load strobes); sum and beat registers stay in ones_accumulator.
REQ-031 Implementation SHALL be flop-based synchronous RTL, no latches, no gated clocks.

Verification
REQ-032 Full window: 8 beats in_count = 3,1,0,2,3,3,1,2 back-to-back, out_ready = 1 -> out_valid one cycle after 8th beat, out_sum = 15, out_beats = 8, held 1 cycle.
REQ-033 Backpressure: full window, out_ready = 0 for 5 cycles -> out_valid and out_sum stable 5 cycles, in_ready = 0, offered beats not consumed; after out_ready, next window starts at 0.
REQ-034 Early flush: beats 2,3,1 then flush together with 4th beat in_count = 2 -> out_sum = 8, out_beats = 4.
REQ-035 Empty flush: flush immediately after reset -> out_valid with out_sum = 0, out_beats = 0.
REQ-036 Max sum: 8 beats of 3 -> out_sum = 24 with no wrap; repeat with WINDOW = 64 -> out_sum = 192, SUM_W = 8.
REQ-037 Reset mid-operation: rst_n low after 5 beats and again during HOLD -> no out_valid emitted, in_ready = 1 after release, next full window sums from 0.
